// File: rtl/mantissa_product_cpa.sv
// Two-stage carry-propagate adder for the 28x28 mantissa product, lane-split per op.
// Define MPCPA_STICKY_EN to add the per-lane sticky output (out_sticky).
module mantissa_product_cpa #(
    parameter int W     = 56,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_sum,
    input  logic [W-1:0]     in_carry,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_prod,
    output logic [1:0]       out_op,
    output logic [TAG_W-1:0] out_tag,
    output logic [3:0]       out_msb
`ifdef MPCPA_STICKY_EN
    ,
    output logic [3:0]       out_sticky
`endif
);

    localparam int H = W / 2;
    localparam int Q = W / 4;

    logic             s1Valid_q;
    logic [H-1:0]     s1Lo_q;
    logic             s1C28_q;
    logic [H-1:0]     s1SumHi_q;
    logic [H-1:0]     s1CarryHi_q;
    logic [1:0]       s1Op_q;
    logic [TAG_W-1:0] s1Tag_q;

    logic             outValid_q;
    logic [W-1:0]     outProd_q;
    logic [1:0]       outOp_q;
    logic [TAG_W-1:0] outTag_q;
    logic [3:0]       outMsb_q;

    logic             s1Adv;
    logic             s2Adv;
    logic [1:0]       opNorm;
    logic [Q:0]       lo0Sum;
    logic             lo0Carry;
    logic [Q:0]       lo1Sum;
    logic [H-1:0]     s1Lo_d;
    logic             s1C28_d;
    logic [Q:0]       hi0Sum;
    logic             hi0Carry;
    logic [Q-1:0]     hi1Sum;
    logic [W-1:0]     outProd_d;
    logic [3:0]       outMsb_d;

    assign s2Adv    = !outValid_q || out_ready;
    assign s1Adv    = !s1Valid_q || s2Adv;
    assign in_ready = s1Adv;

    // Reserved op 11 behaves exactly like a single full-width product.
    assign opNorm   = (in_op == 2'b11) ? 2'b00 : in_op;

    assign lo0Sum   = {1'b0, in_sum[Q-1:0]} + {1'b0, in_carry[Q-1:0]};
    assign lo0Carry = lo0Sum[Q] && (opNorm != 2'b10);
    assign lo1Sum   = {1'b0, in_sum[H-1:Q]} + {1'b0, in_carry[H-1:Q]} + {{Q{1'b0}}, lo0Carry};
    assign s1Lo_d   = {lo1Sum[Q-1:0], lo0Sum[Q-1:0]};
    assign s1C28_d  = lo1Sum[Q];

    always_ff @(posedge clk) begin
        if (rst) begin
            s1Valid_q   <= 1'b0;
            s1Lo_q      <= '0;
            s1C28_q     <= 1'b0;
            s1SumHi_q   <= '0;
            s1CarryHi_q <= '0;
            s1Op_q      <= 2'b00;
            s1Tag_q     <= '0;
        end else if (s1Adv) begin
            s1Valid_q <= in_valid;
            if (in_valid) begin
                s1Lo_q      <= s1Lo_d;
                s1C28_q     <= s1C28_d;
                s1SumHi_q   <= in_sum[W-1:H];
                s1CarryHi_q <= in_carry[W-1:H];
                s1Op_q      <= opNorm;
                s1Tag_q     <= in_tag;
            end
        end
    end

    // The low-half carry only crosses into the upper half for a single full product.
    assign hi0Sum    = {1'b0, s1SumHi_q[Q-1:0]} + {1'b0, s1CarryHi_q[Q-1:0]}
                     + {{Q{1'b0}}, s1C28_q && (s1Op_q == 2'b00)};
    assign hi0Carry  = hi0Sum[Q] && (s1Op_q != 2'b10);
    assign hi1Sum    = s1SumHi_q[H-1:Q] + s1CarryHi_q[H-1:Q] + {{(Q-1){1'b0}}, hi0Carry};
    assign outProd_d = {hi1Sum, hi0Sum[Q-1:0], s1Lo_q};

    always_comb begin
        outMsb_d = 4'b0000;
        case (s1Op_q)
            2'b00:   outMsb_d = {3'b000, outProd_d[W-1]};
            2'b01:   outMsb_d = {2'b00, outProd_d[W-1], outProd_d[H-1]};
            2'b10:   outMsb_d = {outProd_d[W-1], outProd_d[H+Q-1], outProd_d[H-1], outProd_d[Q-1]};
            default: outMsb_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outValid_q <= 1'b0;
            outProd_q  <= '0;
            outOp_q    <= 2'b00;
            outTag_q   <= '0;
            outMsb_q   <= 4'b0000;
        end else if (s2Adv) begin
            outValid_q <= s1Valid_q;
            if (s1Valid_q) begin
                outProd_q <= outProd_d;
                outOp_q   <= s1Op_q;
                outTag_q  <= s1Tag_q;
                outMsb_q  <= outMsb_d;
            end
        end
    end

    assign out_valid = outValid_q;
    assign out_prod  = outProd_q;
    assign out_op    = outOp_q;
    assign out_tag   = outTag_q;
    assign out_msb   = outMsb_q;

`ifdef MPCPA_STICKY_EN
    logic [3:0] outSticky_q;
    logic [3:0] outSticky_d;

    // Sticky covers everything below each lane's top 16 bits; 14-b lanes have none.
    always_comb begin
        outSticky_d = 4'b0000;
        case (s1Op_q)
            2'b00:   outSticky_d = {3'b000, |outProd_d[W-17:0]};
            2'b01:   outSticky_d = {2'b00, |outProd_d[W-17:H], |outProd_d[H-17:0]};
            default: outSticky_d = 4'b0000;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outSticky_q <= 4'b0000;
        end else if (s2Adv && s1Valid_q) begin
            outSticky_q <= outSticky_d;
        end
    end

    assign out_sticky = outSticky_q;
`endif

endmodule

// File: tb/tb_mantissa_product_cpa.sv
// Self-checking bench for mantissa_product_cpa: directed cases, backpressure, reset flush
// and randomized traffic scored against a lane-arithmetic reference model.
module tb_mantissa_product_cpa;

    localparam int W     = 56;
    localparam int TAG_W = 4;
    localparam int NRAND = 10000;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_sum;
    logic [W-1:0]     in_carry;
    logic [1:0]       in_op;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_prod;
    logic [1:0]       out_op;
    logic [TAG_W-1:0] out_tag;
    logic [3:0]       out_msb;
`ifdef MPCPA_STICKY_EN
    logic [3:0]       out_sticky;
`endif

    always #5 clk = ~clk;

    mantissa_product_cpa #(.W(W), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sum    (in_sum),
        .in_carry  (in_carry),
        .in_op     (in_op),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_prod  (out_prod),
        .out_op    (out_op),
        .out_tag   (out_tag),
`ifdef MPCPA_STICKY_EN
        .out_sticky(out_sticky),
`endif
        .out_msb   (out_msb)
    );

    typedef struct {
        logic [W-1:0]     prod;
        logic [1:0]       op;
        logic [TAG_W-1:0] tag;
        logic [3:0]       msb;
        logic [3:0]       sticky;
    } expT;

    expT expQ[$];
    int  checkCount = 0;
    int  passCount  = 0;
    int  outCount   = 0;

    logic             heldValid = 1'b0;
    logic [W-1:0]     heldProd;
    logic [TAG_W-1:0] heldTag;

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) passCount++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    endtask

    function automatic int laneWidth(input logic [1:0] op);
        if (op == 2'b01) return 28;
        if (op == 2'b10) return 14;
        return 56;
    endfunction

    // Each lane is an independent unsigned sum modulo 2^laneWidth.
    function automatic logic [W-1:0] refProd(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        int lw;
        longint unsigned mask, x, y;
        logic [W-1:0] r;
        lw   = laneWidth(op);
        mask = (64'd1 << lw) - 64'd1;
        r    = '0;
        for (int l = 0; l < W / lw; l++) begin
            x = longint'(a >> (l * lw)) & mask;
            y = longint'(b >> (l * lw)) & mask;
            r = r | (W'((x + y) & mask) << (l * lw));
        end
        return r;
    endfunction

    function automatic logic [3:0] refMsb(input logic [1:0] op, input logic [W-1:0] p);
        int lw;
        logic [3:0] m;
        lw = laneWidth(op);
        m  = 4'b0000;
        for (int l = 0; l < W / lw; l++) m[l] = p[(l + 1) * lw - 1];
        return m;
    endfunction

    function automatic logic [3:0] refSticky(input logic [1:0] op, input logic [W-1:0] p);
        int lw;
        longint unsigned mask;
        logic [3:0] s;
        lw = laneWidth(op);
        s  = 4'b0000;
        if (lw > 16) begin
            mask = (64'd1 << (lw - 16)) - 64'd1;
            for (int l = 0; l < W / lw; l++) s[l] = ((longint'(p >> (l * lw)) & mask) != 0);
        end
        return s;
    endfunction

    // Scoreboard: record accepted inputs, compare transferred outputs, verify stall stability.
    always @(negedge clk) begin
        expT e;
        logic [1:0] opn;
        if (rst) begin
            expQ.delete();
            heldValid = 1'b0;
        end else begin
            if (heldValid) begin
                checkOutput("holdValid", 64'(out_valid), 64'd1);
                checkOutput("holdProd", 64'(out_prod), 64'(heldProd));
                checkOutput("holdTag", 64'(out_tag), 64'(heldTag));
            end
            heldValid = out_valid && !out_ready;
            heldProd  = out_prod;
            heldTag   = out_tag;
            if (out_valid && out_ready) begin
                outCount++;
                if (expQ.size() == 0) begin
                    checkOutput("outWithoutInput", 64'(expQ.size()), 64'd1);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("prod", 64'(out_prod), 64'(e.prod));
                    checkOutput("op", 64'(out_op), 64'(e.op));
                    checkOutput("tag", 64'(out_tag), 64'(e.tag));
                    checkOutput("msb", 64'(out_msb), 64'(e.msb));
`ifdef MPCPA_STICKY_EN
                    checkOutput("sticky", 64'(out_sticky), 64'(e.sticky));
`endif
                end
            end
            if (in_valid && in_ready) begin
                opn      = (in_op == 2'b11) ? 2'b00 : in_op;
                e.prod   = refProd(opn, in_sum, in_carry);
                e.op     = opn;
                e.tag    = in_tag;
                e.msb    = refMsb(opn, e.prod);
                e.sticky = refSticky(opn, e.prod);
                expQ.push_back(e);
            end
        end
    end

    function automatic logic [W-1:0] rand56();
        logic [63:0] t;
        t = {$urandom(), $urandom()};
        return t[W-1:0];
    endfunction

    task automatic applyStimulus(input logic [1:0] op, input logic [W-1:0] s, input logic [W-1:0] c,
                                 input logic [TAG_W-1:0] tag);
        logic acc;
        logic accepted;
        accepted = 1'b0;
        in_op    = op;
        in_sum   = s;
        in_carry = c;
        in_tag   = tag;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !accepted; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            accepted = acc;
        end
        checkOutput("accept", 64'(accepted), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 200 && (expQ.size() != 0 || out_valid); i++) begin
            @(posedge clk);
            #1;
        end
        checkOutput(name, 64'(expQ.size()), 64'd0);
    endtask

    task automatic runDirected(input string name, input logic [1:0] op, input logic [W-1:0] s,
                               input logic [W-1:0] c, input logic [W-1:0] expProd, input logic [3:0] expMsb);
        out_ready = 1'b1;
        applyStimulus(op, s, c, 4'hA);
        @(posedge clk);
        #1;
        checkOutput({name, "Valid"}, 64'(out_valid), 64'd1);
        checkOutput({name, "Prod"}, 64'(out_prod), 64'(expProd));
        checkOutput({name, "Msb"}, 64'(out_msb), 64'(expMsb));
        waitDrain({name, "Drain"});
    endtask

    initial begin
        int  sent;
        int  cycles;
        int  outBefore;
        logic acc;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sum    = '0;
        in_carry  = '0;
        in_op     = 2'b00;
        in_tag    = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rstValid", 64'(out_valid), 64'd0);
        checkOutput("rstProd", 64'(out_prod), 64'd0);
        checkOutput("rstMsb", 64'(out_msb), 64'd0);
        checkOutput("rstReady", 64'(in_ready), 64'd1);

        runDirected("op00Carry", 2'b00, 56'h0FFFFFFF, 56'h1, 56'h10000000, 4'b0000);
        runDirected("op01Kill28", 2'b01, 56'h0FFFFFFF, 56'h1, 56'h0, 4'b0000);
        runDirected("op01Drop55", 2'b01, 56'hFFFFFFF_0000000, 56'h10000000, 56'h0, 4'b0000);
        runDirected("op10Kill14", 2'b10, 56'h3FFF, 56'h1, 56'h0, 4'b0000);
        runDirected("op10Msb", 2'b10, 56'h2000, 56'h0, 56'h2000, 4'b0001);
        runDirected("op11AsOp00", 2'b11, 56'h0FFFFFFF, 56'h1, 56'h10000000, 4'b0000);
        runDirected("op00Msb", 2'b00, 56'h80000000000000, 56'h0, 56'h80000000000000, 4'b0001);

        // Backpressure: two ops fill the pipe, the rest wait until the sink releases.
        out_ready = 1'b0;
        in_op     = 2'b00;
        in_sum    = rand56();
        in_carry  = rand56();
        in_tag    = 4'd1;
        in_valid  = 1'b1;
        @(posedge clk);
        #1;
        in_sum   = rand56();
        in_carry = rand56();
        in_tag   = 4'd2;
        @(posedge clk);
        #1;
        in_sum   = rand56();
        in_carry = rand56();
        in_tag   = 4'd3;
        for (int i = 0; i < 5; i++) begin
            checkOutput("bpInReady", 64'(in_ready), 64'd0);
            checkOutput("bpOutTag", 64'(out_tag), 64'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        sent = 2;
        for (int i = 0; i < 50 && sent < 4; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                sent++;
                in_sum   = rand56();
                in_carry = rand56();
                in_tag   = 4'(sent + 1);
            end
        end
        in_valid = 1'b0;
        checkOutput("bpSent", 64'(sent), 64'd4);
        waitDrain("bpDrain");

        // Reset with two ops in flight must discard both.
        out_ready = 1'b0;
        applyStimulus(2'b00, rand56(), rand56(), 4'd5);
        applyStimulus(2'b01, rand56(), rand56(), 4'd6);
        rst = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("midRstValid", 64'(out_valid), 64'd0);
        checkOutput("midRstProd", 64'(out_prod), 64'd0);
        checkOutput("midRstOp", 64'(out_op), 64'd0);
        checkOutput("midRstTag", 64'(out_tag), 64'd0);
        checkOutput("midRstMsb", 64'(out_msb), 64'd0);
        checkOutput("midRstReady", 64'(in_ready), 64'd1);
        rst       = 1'b0;
        out_ready = 1'b1;
        outBefore = outCount;
        applyStimulus(2'b10, rand56(), rand56(), 4'd7);
        waitDrain("postRstDrain");
        checkOutput("postRstOut", 64'(outCount - outBefore), 64'd1);

        // Randomized traffic with random sink stalls.
        sent   = 0;
        cycles = 0;
        while (sent < NRAND && cycles < 60000) begin
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk);
            #1;
            cycles++;
            if (acc) sent++;
            if (!in_valid || acc) begin
                if (sent < NRAND && $urandom_range(0, 9) < 7) begin
                    in_op    = 2'($urandom_range(0, 3));
                    in_sum   = rand56();
                    in_carry = rand56();
                    in_tag   = 4'($urandom_range(0, 15));
                    in_valid = 1'b1;
                end else begin
                    in_valid = 1'b0;
                end
            end
            out_ready = ($urandom_range(0, 9) < 7);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        checkOutput("randSent", 64'(sent), 64'(NRAND));
        waitDrain("randDrain");

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
